// File: rtl/step_phase_decoder_if.sv
// rtl/step_phase_decoder_if.sv - phase-line inputs and decoded outputs of step_phase_decoder
interface step_phase_decoder_if #(parameter int PW = 20);
  logic          A, B, C, D;
  logic          clr_fault;
  logic [1:0]    pos;
  logic          locked;
  logic          dir;
  logic          step_pulse;
  logic [15:0]   step_cnt;
  logic [PW-1:0] step_period;
  logic          stall;
  logic          fault;

  modport master (
    output A, B, C, D, clr_fault,
    input  pos, locked, dir, step_pulse, step_cnt, step_period, stall, fault
  );

  modport slave (
    input  A, B, C, D, clr_fault,
    output pos, locked, dir, step_pulse, step_cnt, step_period, stall, fault
  );
endinterface

// File: rtl/step_phase_decoder.sv
// rtl/step_phase_decoder.sv - recovers rotor position, direction, count and period from chopped stepper phase lines
// STALL must not exceed 2^PW-1 since stall is judged on the saturating period counter.
module step_phase_decoder #(
  parameter int WIN   = 32768,
  parameter int STALL = 1048575,
  parameter int PW    = 20
) (
  input logic                 clk,
  input logic                 reset,
  step_phase_decoder_if.slave bus
);
  localparam int              AW         = (WIN > 2) ? $clog2(WIN) : 1;
  localparam logic [AW-1:0]   WIN_RELOAD = AW'(WIN - 1);
  localparam logic [PW-1:0]   PMAX       = '1;
  localparam logic [PW-1:0]   STALL_TH   = PW'(STALL);
  localparam logic [2:0]      CLS_HOLD   = 3'd4;
  localparam logic [2:0]      CLS_ILL    = 3'd5;

  typedef enum logic {IDLE, TRACK} state_t;

  logic [3:0]    sync1_q, sync2_q, act;
  logic [AW-1:0] act_cnt_q [4];
  logic [AW-1:0] act_cnt_d [4];
  logic [2:0]    cls_d, cls_q, cls1_q, cls2_q, cls3_q;
  logic          qual;

  state_t        state_q, state_d;
  logic [1:0]    pos_q, pos_d, delta;
  logic          locked_q, locked_d, dir_q, dir_d, pulse_q, pulse_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [PW-1:0] period_q, period_d, pcnt_q, pcnt_d, pcnt_inc;
  logic          stall_q, stall_d, fault_q, fault_d, fault_new;

  // Bit 3 is phase A down to bit 0 for phase D.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      act_cnt_d[i] = sync2_q[i] ? WIN_RELOAD
                   : ((act_cnt_q[i] != '0) ? act_cnt_q[i] - 1'b1 : '0);
      act[i]       = sync2_q[i] | (act_cnt_q[i] != '0);
    end
  end

  always_comb begin
    cls_d = CLS_ILL;
    case (act)
      4'b1100: cls_d = 3'd0;
      4'b0110: cls_d = 3'd1;
      4'b0011: cls_d = 3'd2;
      4'b1001: cls_d = 3'd3;
      4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001: cls_d = CLS_HOLD;
      default: cls_d = CLS_ILL;
    endcase
  end

  assign qual     = (cls_q == cls1_q) && (cls1_q == cls2_q) && (cls2_q == cls3_q);
  assign delta    = cls_q[1:0] - pos_q;
  assign pcnt_inc = (pcnt_q == PMAX) ? PMAX : pcnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    locked_d  = locked_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    period_d  = period_q;
    pcnt_d    = pcnt_q;
    fault_new = 1'b0;
    case (state_q)
      IDLE: begin
        if (qual && !cls_q[2]) begin
          pos_d    = cls_q[1:0];
          locked_d = 1'b1;
          pcnt_d   = '0;
          state_d  = TRACK;
        end
      end
      TRACK: begin
        pcnt_d = pcnt_inc;
        if (qual && cls_q == CLS_ILL) begin
          fault_new = 1'b1;
        end else if (qual && !cls_q[2]) begin
          case (delta)
            2'd1, 2'd3: begin
              pos_d    = cls_q[1:0];
              dir_d    = (delta == 2'd1);
              cnt_d    = (delta == 2'd1) ? cnt_q + 16'd1 : cnt_q - 16'd1;
              pulse_d  = 1'b1;
              period_d = pcnt_inc;
              pcnt_d   = '0;
            end
            2'd2: begin
              pos_d     = cls_q[1:0];
              fault_new = 1'b1;
              pcnt_d    = '0;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    fault_d = fault_new | (fault_q & ~bus.clr_fault);
    stall_d = (state_d == TRACK) && (pcnt_d >= STALL_TH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      for (int i = 0; i < 4; i++) act_cnt_q[i] <= '0;
      cls_q    <= CLS_HOLD;
      cls1_q   <= CLS_HOLD;
      cls2_q   <= CLS_HOLD;
      cls3_q   <= CLS_HOLD;
      state_q  <= IDLE;
      pos_q    <= '0;
      locked_q <= 1'b0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      period_q <= '0;
      pcnt_q   <= '0;
      stall_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync1_q  <= {bus.A, bus.B, bus.C, bus.D};
      sync2_q  <= sync1_q;
      for (int i = 0; i < 4; i++) act_cnt_q[i] <= act_cnt_d[i];
      cls_q    <= cls_d;
      cls1_q   <= cls_q;
      cls2_q   <= cls1_q;
      cls3_q   <= cls2_q;
      state_q  <= state_d;
      pos_q    <= pos_d;
      locked_q <= locked_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      period_q <= period_d;
      pcnt_q   <= pcnt_d;
      stall_q  <= stall_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.pos         = pos_q;
  assign bus.locked      = locked_q;
  assign bus.dir         = dir_q;
  assign bus.step_pulse  = pulse_q;
  assign bus.step_cnt    = cnt_q;
  assign bus.step_period = period_q;
  assign bus.stall       = stall_q;
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_step_phase_decoder.sv
// tb/tb_step_phase_decoder.sv - directed and randomized bench for step_phase_decoder with a behavioural model
module tb_step_phase_decoder;
  localparam int WIN   = 64;
  localparam int STALL = 1000;
  localparam int PW    = 10;
  localparam int PMAX  = (1 << PW) - 1;
  localparam logic [3:0] P_AB = 4'b1100, P_BC = 4'b0110, P_CD = 4'b0011, P_DA = 4'b1001;
  localparam logic [3:0] P_AC = 4'b1010, P_BD = 4'b0101;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ph = 4'b0000;
  logic       clr = 1'b0;

  always #5 clk = ~clk;

  step_phase_decoder_if #(.PW(PW)) bus ();
  assign bus.A = ph[3];
  assign bus.B = ph[2];
  assign bus.C = ph[1];
  assign bus.D = ph[0];
  assign bus.clr_fault = clr;

  step_phase_decoder #(.WIN(WIN), .STALL(STALL), .PW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Model state: phase activity is "high within the last WIN sampled cycles",
  // candidates are acted on 7 clocks after the synchroniser sees them once
  // four consecutive ones agree.
  int          k = 0;
  int          last_high [4];
  int          hist [6];
  logic [3:0]  m_act;
  int          m_cand, m_diff, m_pos, m_ev, m_period;
  bit          m_qual, m_newf, m_locked, m_dir, m_pulse, m_stall, m_fault;
  logic [15:0] m_cnt;

  function automatic int classify(input logic [3:0] a);
    if ($countones(a) <= 1) return 4;
    if ($countones(a) >= 3) return 5;
    for (int p = 0; p < 4; p++)
      if (a[3 - p] && a[3 - ((p + 1) % 4)]) return p;
    return 5;
  endfunction

  function automatic logic [63:0] outs();
    return {31'd0, bus.pos, bus.locked, bus.dir, bus.step_pulse, bus.step_cnt,
            bus.step_period, bus.stall, bus.fault};
  endfunction

  always @(posedge clk) begin
    k++;
    if (!reset) begin
      for (int i = 0; i < 4; i++) last_high[i] = -1000000;
      for (int i = 0; i < 6; i++) hist[i] = 4;
      m_locked = 0; m_dir = 0; m_pulse = 0; m_stall = 0; m_fault = 0;
      m_pos = 0; m_ev = 0; m_period = 0; m_cnt = '0;
    end else begin
      for (int i = 0; i < 4; i++) m_act[i] = (last_high[i] >= k - WIN);
      for (int i = 0; i < 4; i++) if (ph[i]) last_high[i] = k;
      for (int i = 5; i > 0; i--) hist[i] = hist[i - 1];
      hist[0] = classify(m_act);
      m_cand  = hist[2];
      m_qual  = (hist[3] == m_cand) && (hist[4] == m_cand) && (hist[5] == m_cand);
      m_pulse = 0;
      m_newf  = 0;
      if (m_qual && !m_locked && m_cand < 4) begin
        m_locked = 1;
        m_pos    = m_cand;
        m_ev     = k;
      end else if (m_qual && m_locked) begin
        if (m_cand == 5) begin
          m_newf = 1;
        end else if (m_cand < 4 && m_cand != m_pos) begin
          m_diff = (m_cand - m_pos + 4) % 4;
          if (m_diff == 2) begin
            m_newf = 1;
          end else begin
            m_pulse  = 1;
            m_dir    = (m_diff == 1);
            m_cnt    = m_dir ? m_cnt + 16'd1 : m_cnt - 16'd1;
            m_period = (k - m_ev > PMAX) ? PMAX : k - m_ev;
          end
          m_pos = m_cand;
          m_ev  = k;
        end
      end
      m_fault = m_newf || (m_fault && !clr);
      m_stall = m_locked && (k - m_ev >= STALL);
    end
    #1;
    checks++;
    if (outs() !== {31'd0, m_pos[1:0], m_locked, m_dir, m_pulse, m_cnt,
                    m_period[PW-1:0], m_stall, m_fault}) begin
      errors++;
      $display("FAIL model_cycle k=%0d got pos=%0d lk=%0b dir=%0b pl=%0b cnt=%h per=%0d st=%0b f=%0b want pos=%0d lk=%0b dir=%0b pl=%0b cnt=%h per=%0d st=%0b f=%0b",
               k, bus.pos, bus.locked, bus.dir, bus.step_pulse, bus.step_cnt, bus.step_period,
               bus.stall, bus.fault, m_pos, m_locked, m_dir, m_pulse, m_cnt, m_period,
               m_stall, m_fault);
    end
    if (bus.step_pulse) pulses++;
  end

  task automatic expect_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  // Called at a negedge; returns at a negedge after n cycles.
  task automatic hold(input logic [3:0] p, input int n, input int frame, input int hi);
    for (int i = 0; i < n; i++) begin
      ph = (frame == 0 || (i % frame) < hi) ? p : 4'b0000;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ph    = 4'b0000;
    clr   = 1'b0;
    repeat (3) @(negedge clk);
    expect_eq("reset_outputs", outs(), 64'd0);
    reset = 1'b1;
  endtask

  int          wait_cyc;
  bit          seen, prev_stall;
  logic [3:0]  rp;
  logic [3:0]  valid_p [4];

  initial begin
    valid_p[0] = P_AB; valid_p[1] = P_BC; valid_p[2] = P_CD; valid_p[3] = P_DA;
    @(negedge clk);

    // Lock: 7-clock latency, no counting
    do_reset();
    hold(P_AB, 6, 0, 0);
    expect_eq("lock_not_yet", bus.locked, 0);
    hold(P_AB, 1, 0, 0);
    expect_eq("lock_locked", bus.locked, 1);
    expect_eq("lock_pos", bus.pos, 0);
    pulses = 0;
    hold(P_AB, 50, 0, 0);
    expect_eq("lock_no_pulse", pulses, 0);
    expect_eq("lock_cnt", bus.step_cnt, 0);

    // Forward steps
    do_reset();
    hold(P_AB, 200, 0, 0); hold(P_BC, 200, 0, 0); hold(P_CD, 200, 0, 0);
    hold(P_DA, 200, 0, 0); hold(P_AB, 200, 0, 0);
    expect_eq("fwd_cnt", bus.step_cnt, 16'd4);
    expect_eq("fwd_dir", bus.dir, 1);
    expect_eq("fwd_pos", bus.pos, 0);
    expect_eq("fwd_period", bus.step_period, 200);

    // Asynchronous reset mid-operation, then reacquire without counting
    reset = 1'b0;
    #1;
    expect_eq("async_reset", outs(), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    hold(P_BC, 20, 0, 0);
    expect_eq("relock_pos", bus.pos, 1);
    expect_eq("relock_cnt", bus.step_cnt, 0);

    // Reverse steps
    do_reset();
    hold(P_AB, 100, 0, 0); hold(P_DA, 100, 0, 0); hold(P_CD, 100, 0, 0); hold(P_BC, 100, 0, 0);
    expect_eq("rev_cnt", bus.step_cnt, 16'hFFFD);
    expect_eq("rev_dir", bus.dir, 0);
    expect_eq("rev_period", bus.step_period, 100);

    // PWM chop with a single-phase gap
    do_reset();
    pulses = 0;
    hold(P_AB, 300, 50, 2); hold(4'b0100, 100, 50, 2); hold(P_BC, 300, 50, 2);
    expect_eq("chop_pulses", pulses, 1);
    expect_eq("chop_fault", bus.fault, 0);
    expect_eq("chop_pos", bus.pos, 1);

    // Faults: skipped step, clear, illegal pattern
    do_reset();
    hold(P_AB, 100, 0, 0); hold(P_CD, 150, 0, 0);
    expect_eq("skip_fault", bus.fault, 1);
    expect_eq("skip_pos", bus.pos, 2);
    expect_eq("skip_cnt", bus.step_cnt, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    expect_eq("clr_fault", bus.fault, 0);
    hold(P_AC, 150, 0, 0);
    expect_eq("illegal_fault", bus.fault, 1);
    expect_eq("illegal_pos", bus.pos, 2);

    // Stall, then a step that clears it with a saturated period
    do_reset();
    hold(P_AB, 1100, 0, 0);
    expect_eq("stall_set", bus.stall, 1);
    ph = P_BC;
    seen = 0;
    wait_cyc = 0;
    prev_stall = bus.stall;
    while (!seen && wait_cyc < 300) begin
      prev_stall = bus.stall;
      @(negedge clk);
      wait_cyc++;
      if (bus.step_pulse) seen = 1;
    end
    expect_eq("stall_step_seen", seen, 1);
    expect_eq("stall_before_step", prev_stall, 1);
    expect_eq("stall_cleared", bus.stall, 0);
    expect_eq("period_saturated", bus.step_period, PMAX);

    // Randomized patterns, glitches, chop and fault clears
    do_reset();
    for (int s = 0; s < 70; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: rp = valid_p[$urandom_range(0, 3)];
        6:       rp = 4'b1000 >> $urandom_range(0, 3);
        7:       rp = 4'b0000;
        8:       rp = $urandom_range(0, 1) ? P_AC : P_BD;
        default: rp = $urandom_range(0, 1) ? 4'b1111 : 4'b1110;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
      if ($urandom_range(0, 2) == 0)
        hold(rp, $urandom_range(1, 200), $urandom_range(10, 50), $urandom_range(1, 3));
      else
        hold(rp, $urandom_range(1, 200), 0, 0);
    end
    hold(4'b0000, 10, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
